// File: rtl/cv32e40x_pkg.sv
// Shared types for the cv32e40x divider slice: operator encoding, FSM states, counter width.
package cv32e40x_pkg;

   typedef enum logic [1:0] {
      DIV_DIVU = 2'b00,
      DIV_DIV  = 2'b01,
      DIV_REMU = 2'b10,
      DIV_REM  = 2'b11
   } div_opcode_e;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_DIVIDE,
      DIV_DONE
   } div_state_e;

   localparam int unsigned DIV_CNT_W = 6;

endpackage

// File: rtl/cv32e40x_div_clz.sv
// 32-bit leading-zero counter; yields 32 for an all-zero input.
module cv32e40x_div_clz
   import cv32e40x_pkg::*;
(
   input  logic [31:0]          data,
   output logic [DIV_CNT_W-1:0] cnt
);

   // Scanning from LSB upward leaves the highest set bit as the final writer.
   always_comb begin
      cnt = DIV_CNT_W'(32);
      for (int unsigned i = 0; i < 32; i++) begin
         if (data[i]) cnt = DIV_CNT_W'(31 - i);
      end
   end

endmodule

// File: rtl/cv32e40x_div_seq.sv
// Iterative radix-2 restoring divider (div/divu/rem/remu), one quotient bit per cycle.
// Define CV32E40X_DIV_EARLY_TERM_EN to skip leading-zero dividend bits at accept.
module cv32e40x_div_seq
   import cv32e40x_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   output logic        ready_o,
   input  div_opcode_e operator_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic        kill_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] result_o
);

   div_state_e           state;
   logic [DIV_CNT_W-1:0] cnt;
   logic [31:0]          rem, quo, div_mag;
   logic                 op_rem, neg_q, neg_r;

   logic        in_signed, in_rem;
   logic [31:0] a_mag, b_mag;
   logic [32:0] trial, diff;
   logic        qbit;
   logic [31:0] rem_nxt, quo_nxt, res_fix;

   assign in_signed = (operator_i == DIV_DIV) || (operator_i == DIV_REM);
   assign in_rem    = (operator_i == DIV_REM) || (operator_i == DIV_REMU);
   // Unsigned 32-bit negation maps -2^31 to magnitude 2^31 without overflow.
   assign a_mag     = (in_signed && op_a_i[31]) ? -op_a_i : op_a_i;
   assign b_mag     = (in_signed && op_b_i[31]) ? -op_b_i : op_b_i;

   assign trial   = {rem, quo[31]};
   assign diff    = trial - {1'b0, div_mag};
   assign qbit    = ~diff[32];
   assign rem_nxt = qbit ? diff[31:0] : trial[31:0];
   assign quo_nxt = {quo[30:0], qbit};
   assign res_fix = op_rem ? (neg_r ? -rem_nxt : rem_nxt)
                           : (neg_q ? -quo_nxt : quo_nxt);

`ifdef CV32E40X_DIV_EARLY_TERM_EN
   logic [DIV_CNT_W-1:0] clz;

   cv32e40x_div_clz u_clz (
      .data (a_mag),
      .cnt  (clz)
   );
`endif

   assign ready_o = (state == DIV_IDLE);
   assign valid_o = (state == DIV_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= DIV_IDLE;
         cnt      <= '0;
         rem      <= '0;
         quo      <= '0;
         div_mag  <= '0;
         op_rem   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_o <= '0;
      end else if (kill_i) begin
         state <= DIV_IDLE;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (valid_i) begin
                  op_rem  <= in_rem;
                  neg_q   <= in_signed && (op_a_i[31] ^ op_b_i[31]);
                  neg_r   <= in_signed && op_a_i[31];
                  rem     <= '0;
                  div_mag <= b_mag;
                  if (op_b_i == '0) begin
                     result_o <= in_rem ? op_a_i : '1;
                     state    <= DIV_DONE;
                  end else if (in_signed && op_a_i == 32'h8000_0000 && op_b_i == '1) begin
                     result_o <= in_rem ? '0 : 32'h8000_0000;
                     state    <= DIV_DONE;
`ifdef CV32E40X_DIV_EARLY_TERM_EN
                  end else if (a_mag == '0) begin
                     result_o <= '0;
                     state    <= DIV_DONE;
                  end else begin
                     quo   <= a_mag << clz;
                     cnt   <= DIV_CNT_W'(32) - clz;
                     state <= DIV_DIVIDE;
                  end
`else
                  end else begin
                     quo   <= a_mag;
                     cnt   <= DIV_CNT_W'(32);
                     state <= DIV_DIVIDE;
                  end
`endif
               end
            end
            DIV_DIVIDE: begin
               rem <= rem_nxt;
               quo <= quo_nxt;
               cnt <= cnt - 1'b1;
               if (cnt == DIV_CNT_W'(1)) begin
                  result_o <= res_fix;
                  state    <= DIV_DONE;
               end
            end
            DIV_DONE: begin
               if (ready_i) state <= DIV_IDLE;
            end
            default: state <= DIV_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cv32e40x_div_seq.sv
// Scoreboard bench for cv32e40x_div_seq: results, latency, backpressure, kill and reset.
module tb_cv32e40x_div_seq;
   import cv32e40x_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic        ready_o;
   div_opcode_e operator_i;
   logic [31:0] op_a_i;
   logic [31:0] op_b_i;
   logic        kill_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] result_o;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   cv32e40x_div_seq dut (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .operator_i (operator_i),
      .op_a_i     (op_a_i),
      .op_b_i     (op_b_i),
      .kill_i     (kill_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .result_o   (result_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic is_signed_op(input div_opcode_e op);
      return (op == DIV_DIV) || (op == DIV_REM);
   endfunction

   function automatic logic is_rem_op(input div_opcode_e op);
      return (op == DIV_REM) || (op == DIV_REMU);
   endfunction

   function automatic logic [31:0] model(input div_opcode_e op, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      if (b == 32'h0) return is_rem_op(op) ? a : 32'hFFFF_FFFF;
      if (is_signed_op(op)) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return is_rem_op(op) ? 32'h0 : 32'h8000_0000;
         sa = a;
         sb = b;
         return is_rem_op(op) ? 32'(sa % sb) : 32'(sa / sb);
      end
      return is_rem_op(op) ? a % b : a / b;
   endfunction

   function automatic int lat_model(input div_opcode_e op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] mag;
      int lz;
      if (b == 32'h0) return 0;
      if (is_signed_op(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      mag = (is_signed_op(op) && a[31]) ? (~a + 32'd1) : a;
`ifdef CV32E40X_DIV_EARLY_TERM_EN
      if (mag == 32'h0) return 0;
      lz = 0;
      while (!mag[31]) begin
         mag = mag << 1;
         lz++;
      end
      return 32 - lz;
`else
      lz = (mag == 32'h0) ? 1 : 0;
      return 32 + 0 * lz;
`endif
   endfunction

   // Drive one operation and hold the request for a single accept edge.
   task automatic issue(input div_opcode_e op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      check("ready_before_accept", {31'b0, ready_o}, 32'd1);
      valid_i    = 1'b1;
      operator_i = op;
      op_a_i     = a;
      op_b_i     = b;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      op_a_i  = $urandom;
      op_b_i  = $urandom;
   endtask

   task automatic run_op(input div_opcode_e op, input logic [31:0] a, input logic [31:0] b, input int hold);
      int lat;
      exp_q.push_back(model(op, a, b));
      issue(op, a, b);
      lat = 0;
      while (!valid_o && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(lat_model(op, a, b)));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", {31'b0, valid_o}, 32'd1);
         check("hold_result", result_o, exp_q[0]);
      end
      @(negedge clk);
      ready_i = 1'b1;
      check("valid_at_handshake", {31'b0, valid_o}, 32'd1);
      check("result", result_o, exp_q.pop_front());
      @(posedge clk);
      #1;
      ready_i = 1'b0;
      check("ready_after_handshake", {31'b0, ready_o}, 32'd1);
      check("valid_after_handshake", {31'b0, valid_o}, 32'd0);
   endtask

   initial begin
      int vcount;
      logic [31:0] ra, rb;
      div_opcode_e rop;
      rst        = 1'b1;
      valid_i    = 1'b0;
      operator_i = DIV_DIVU;
      op_a_i     = '0;
      op_b_i     = '0;
      kill_i     = 1'b0;
      ready_i    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_ready", {31'b0, ready_o}, 32'd1);
      check("reset_valid", {31'b0, valid_o}, 32'd0);
      check("reset_result", result_o, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      run_op(DIV_DIVU, 32'd100, 32'd7, 0);
      run_op(DIV_REMU, 32'd100, 32'd7, 0);
      run_op(DIV_DIV,  32'hFFFF_FFF9, 32'd2, 0);
      run_op(DIV_REM,  32'hFFFF_FFF9, 32'd2, 0);
      run_op(DIV_REM,  32'd7, 32'hFFFF_FFFE, 0);
      run_op(DIV_DIV,  32'd5, 32'd0, 0);
      run_op(DIV_REM,  32'd5, 32'd0, 0);
      run_op(DIV_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(DIV_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(DIV_DIVU, 32'd0, 32'd9, 0);
      run_op(DIV_DIV,  32'h8000_0000, 32'd3, 0);
      run_op(DIV_DIVU, 32'd123_456_789, 32'd1000, 10);

      for (int i = 0; i < 8; i++) begin
         rop = div_opcode_e'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i % 2 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
         run_op(rop, ra, rb, $urandom_range(0, 2));
      end

      // Kill during DIVIDE: no result ever appears.
      issue(DIV_DIVU, 32'hDEAD_BEEF, 32'd3);
      repeat (4) @(posedge clk);
      @(negedge clk);
      kill_i = 1'b1;
      @(posedge clk);
      #1;
      kill_i = 1'b0;
      check("kill_ready", {31'b0, ready_o}, 32'd1);
      vcount = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (valid_o) vcount++;
      end
      check("kill_no_valid", 32'(vcount), 32'd0);

      // Kill together with valid in IDLE: a divide-by-zero would be DONE next cycle if accepted.
      @(negedge clk);
      valid_i    = 1'b1;
      kill_i     = 1'b1;
      operator_i = DIV_DIV;
      op_a_i     = 32'd5;
      op_b_i     = 32'd0;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      kill_i  = 1'b0;
      check("kill_accept_ready", {31'b0, ready_o}, 32'd1);
      check("kill_accept_valid", {31'b0, valid_o}, 32'd0);

      // Reset during DIVIDE, with result_o still holding an older nonzero value.
      run_op(DIV_DIVU, 32'd77, 32'd7, 0);
      issue(DIV_DIVU, 32'h1234_5678, 32'd5);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_valid", {31'b0, valid_o}, 32'd0);
      check("rst_mid_ready", {31'b0, ready_o}, 32'd1);
      check("rst_mid_result", result_o, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      run_op(DIV_DIVU, 32'hFFFF_FFFF, 32'd1, 0);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
